// File: rtl/axi_lite_bram_pkg.sv
// Shared response codes, controller states and address helpers for the
// AXI4-Lite block-RAM slave.
package axi_lite_bram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ACC,
    ST_WR_RESP,
    ST_RD_ACC,
    ST_RD_RESP
  } state_e;

  // Number of byte-offset bits below the word index.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_lite_bram_tdp_ram.sv
// Dual-port RAM: port A byte-write/read, port B read-only; both read-first
// with one-cycle registered outputs.
module axi_lite_bram_tdp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 512,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_en_i,
  input  logic [DW/8-1:0] a_we_i,
  input  logic [IW-1:0]   a_addr_i,
  input  logic [DW-1:0]   a_wdata_i,
  output logic [DW-1:0]   a_rdata_o,
  input  logic            b_en_i,
  input  logic [IW-1:0]   b_addr_i,
  output logic [DW-1:0]   b_rdata_o
);

  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    if (a_en_i) begin
      a_rdata_q <= mem_q[a_addr_i];
      for (int i = 0; i < DW/8; i++) begin
        if (a_we_i[i]) begin
          mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // The fabric output is observable after reset, so only it is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_rdata_q <= '0;
    end else if (b_en_i) begin
      b_rdata_q <= ({1'b0, b_addr_i} < DEPTH_W) ? mem_q[b_addr_i] : '0;
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/axi_lite_bram_dp.sv
// AXI4-Lite slave in front of a dual-port block RAM plus a read-only fabric
// port; one AXI transaction in flight, out-of-range indices answer SLVERR.
module axi_lite_bram_dp
  import axi_lite_bram_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int MEM_DEPTH          = 512,
  parameter int RR_ARB             = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            fab_rd_en,
  input  logic [$clog2(MEM_DEPTH)-1:0]    fab_rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   fab_rd_data
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int SW       = C_S_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = addr_lsb(C_S_AXI_DATA_WIDTH);
  localparam int IW       = $clog2(MEM_DEPTH);
  localparam int XW       = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [XW:0] DEPTH_X = (XW+1)'(MEM_DEPTH);

  state_e        state_q, state_d;
  logic [XW-1:0] idx_q, idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          err_q, err_d;
  logic          prefer_rd_q, prefer_rd_d;

  logic [XW-1:0] aw_idx, ar_idx;
  logic          aw_oob, ar_oob;
  logic          wr_req, rd_req, grant_wr, grant_rd;
  logic          ram_en;
  logic [SW-1:0] ram_we;
  logic [DW-1:0] ram_rdata;
  logic          unused_addr_bits;

  assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign aw_oob = ({1'b0, aw_idx} >= DEPTH_X);
  assign ar_oob = ({1'b0, ar_idx} >= DEPTH_X);
  assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], idx_q};

  // A write needs both AW and W; the arbiter only turns over on contention.
  assign wr_req   = S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_req   = S_AXI_ARVALID;
  assign grant_wr = wr_req && (!rd_req || (RR_ARB == 0) || !prefer_rd_q);
  assign grant_rd = rd_req && !grant_wr;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    err_d       = err_q;
    prefer_rd_d = prefer_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_wr) begin
          state_d = ST_WR_ACC;
          idx_d   = aw_idx;
          wdata_d = S_AXI_WDATA;
          wstrb_d = S_AXI_WSTRB;
          err_d   = aw_oob;
          if (rd_req) prefer_rd_d = 1'b1;
        end else if (grant_rd) begin
          state_d = ST_RD_ACC;
          idx_d   = ar_idx;
          err_d   = ar_oob;
          if (wr_req) prefer_rd_d = 1'b0;
        end
      end
      ST_WR_ACC:  state_d = ST_WR_RESP;
      ST_WR_RESP: if (S_AXI_BREADY) state_d = ST_IDLE;
      ST_RD_ACC:  state_d = ST_RD_RESP;
      ST_RD_RESP: if (S_AXI_RREADY) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      err_q       <= 1'b0;
      prefer_rd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      err_q       <= err_d;
      prefer_rd_q <= prefer_rd_d;
    end
  end

  // The RAM is touched only in the accept cycle, so RDATA stays put in RD_RESP.
  assign ram_en = ((state_q == ST_WR_ACC) || (state_q == ST_RD_ACC)) && !err_q;
  assign ram_we = ((state_q == ST_WR_ACC) && !err_q) ? wstrb_q : '0;

  axi_lite_bram_tdp_ram #(
    .DW    (DW),
    .DEPTH (MEM_DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk       (ACLK),
    .rst       (ARESET),
    .a_en_i    (ram_en),
    .a_we_i    (ram_we),
    .a_addr_i  (idx_q[IW-1:0]),
    .a_wdata_i (wdata_q),
    .a_rdata_o (ram_rdata),
    .b_en_i    (fab_rd_en),
    .b_addr_i  (fab_rd_addr),
    .b_rdata_o (fab_rd_data)
  );

  assign S_AXI_AWREADY = (state_q == ST_WR_ACC);
  assign S_AXI_WREADY  = (state_q == ST_WR_ACC);
  assign S_AXI_BVALID  = (state_q == ST_WR_RESP);
  assign S_AXI_BRESP   = ((state_q == ST_WR_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_ARREADY = (state_q == ST_RD_ACC);
  assign S_AXI_RVALID  = (state_q == ST_RD_RESP);
  assign S_AXI_RRESP   = ((state_q == ST_RD_RESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign S_AXI_RDATA   = ((state_q == ST_RD_RESP) && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_lite_bram_dp.sv
// Self-checking bench: directed vector table, hand-written handshake corner
// cases, and a randomized run against a word-array reference model.
module tb_axi_lite_bram_dp;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 512;

  logic          aclk = 1'b0;
  logic          areset;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          fab_en;
  logic [8:0]    fab_addr;

  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata, fab_data;

  logic          f_awready, f_wready, f_bvalid, f_arready, f_rvalid;
  logic [1:0]    f_bresp, f_rresp;
  logic [DW-1:0] f_rdata, f_fab_data;

  int            sel;
  logic          v_awready, v_bvalid, v_arready, v_rvalid;
  logic [1:0]    v_bresp, v_rresp;
  logic [DW-1:0] v_rdata;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];

  always #5 aclk = ~aclk;

  axi_lite_bram_dp #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RR_ARB(1)) dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .fab_rd_en(fab_en), .fab_rd_addr(fab_addr), .fab_rd_data(fab_data)
  );

  axi_lite_bram_dp #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RR_ARB(0)) dut_fw (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(f_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(f_wready),
    .S_AXI_BRESP(f_bresp), .S_AXI_BVALID(f_bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(f_arready),
    .S_AXI_RDATA(f_rdata), .S_AXI_RRESP(f_rresp), .S_AXI_RVALID(f_rvalid), .S_AXI_RREADY(rready),
    .fab_rd_en(fab_en), .fab_rd_addr(fab_addr), .fab_rd_data(f_fab_data)
  );

  // sel picks which instance the handshake tasks follow.
  always_comb begin
    if (sel == 1) begin
      v_awready = f_awready; v_bvalid = f_bvalid; v_arready = f_arready; v_rvalid = f_rvalid;
      v_bresp = f_bresp; v_rresp = f_rresp; v_rdata = f_rdata;
    end else begin
      v_awready = awready; v_bvalid = bvalid; v_arready = arready; v_rvalid = rvalid;
      v_bresp = bresp; v_rresp = rresp; v_rdata = rdata;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; fab_en = 0;
    #1;
    @(negedge aclk) areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    lat = -1; resp = 2'b11;
    for (int c = 1; c <= 50; c++) begin
      @(posedge aclk); #1;
      if (v_awready) begin awvalid = 0; wvalid = 0; end
      if (v_bvalid) begin resp = v_bresp; lat = c; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL write_timeout: addr 0x%0h no BVALID within 50 cycles", a);
      awvalid = 0; wvalid = 0;
    end else begin
      @(posedge aclk); #1;
    end
    bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int lat);
    araddr = a; arvalid = 1; rready = 1;
    lat = -1; resp = 2'b11; d = '0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge aclk); #1;
      if (v_arready) arvalid = 0;
      if (v_rvalid) begin resp = v_rresp; d = v_rdata; lat = c; break; end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL read_timeout: addr 0x%0h no RVALID within 50 cycles", a);
      arvalid = 0;
    end else begin
      @(posedge aclk); #1;
    end
    rready = 0;
  endtask

  // Drives AW/W and AR together; returns grant order (1 = write, 2 = read).
  task automatic contend(input logic [AW-1:0] wa, input logic [AW-1:0] ra,
                         output int first, output int second);
    int seq[$];
    bit wdone = 0;
    bit rdone = 0;
    awaddr = wa; wdata = 32'h5A5A_0000 | 32'(wa); wstrb = 4'hF; araddr = ra;
    awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
    for (int c = 0; c < 40 && !(wdone && rdone); c++) begin
      @(posedge aclk); #1;
      if (v_awready && !wdone) begin awvalid = 0; wvalid = 0; wdone = 1; seq.push_back(1); end
      if (v_arready && !rdone) begin arvalid = 0; rdone = 1; seq.push_back(2); end
    end
    repeat (3) @(posedge aclk);
    #1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    first  = (seq.size() > 0) ? seq[0] : 0;
    second = (seq.size() > 1) ? seq[1] : 0;
  endtask

  task automatic model_wr(input int idx, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    if (idx >= DEPTH) begin
      resp = 2'b10;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
      resp = 2'b00;
    end
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    return (idx >= DEPTH) ? 32'h0 : model_mem[idx];
  endfunction

  typedef struct {
    bit          is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  resp, eresp;
    logic [31:0] d, ed;
    int          lat, f1, s1, f2, s2, hb, ha, bad, seen;

    vecs[0]  = '{1, 12'h000, 32'h1,        4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1, 12'h004, 32'h2,        4'hF, 2'b00, 32'h0};
    vecs[2]  = '{1, 12'h008, 32'h3,        4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1, 12'h00C, 32'h4,        4'hF, 2'b00, 32'h0};
    vecs[4]  = '{0, 12'h000, 32'h0,        4'h0, 2'b00, 32'h1};
    vecs[5]  = '{0, 12'h004, 32'h0,        4'h0, 2'b00, 32'h2};
    vecs[6]  = '{0, 12'h008, 32'h0,        4'h0, 2'b00, 32'h3};
    vecs[7]  = '{0, 12'h00C, 32'h0,        4'h0, 2'b00, 32'h4};
    vecs[8]  = '{1, 12'h010, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0};
    vecs[9]  = '{1, 12'h010, 32'h11223344, 4'h5, 2'b00, 32'h0};
    vecs[10] = '{0, 12'h010, 32'h0,        4'h0, 2'b00, 32'hAA22CC44};
    vecs[11] = '{1, 12'h800, 32'hDEAD,     4'hF, 2'b10, 32'h0};
    vecs[12] = '{0, 12'h800, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[13] = '{0, 12'h000, 32'h0,        4'h0, 2'b00, 32'h1};
    vecs[14] = '{0, 12'h013, 32'h0,        4'h0, 2'b00, 32'hAA22CC44};

    sel = 0; areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; fab_en = 0; fab_addr = '0;
    #3;
    check("reset_ctrl", {awready, wready, bvalid, arready, rvalid, bresp, rresp}, 9'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_fab", fab_data, 32'h0);
    @(negedge aclk) areset = 0;
    @(posedge aclk); #1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        $display("vec %0d write addr=0x%03h data=0x%08h strb=%h bresp=%b lat=%0d",
                 i, vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_blat", i), lat, 2);
      end else begin
        axi_read(vecs[i].addr, d, resp, lat);
        $display("vec %0d read  addr=0x%03h rdata=0x%08h rresp=%b lat=%0d", i, vecs[i].addr, d, resp, lat);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
        check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
        check($sformatf("vec%0d_rlat", i), lat, 2);
      end
    end

    // BREADY held low: BVALID must persist and a pending read must wait.
    awaddr = 12'h014; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge aclk); #1;
      if (awready) begin awvalid = 0; wvalid = 0; end
      if (bvalid) seen = 1;
    end
    awvalid = 0; wvalid = 0;
    check("hold_bvalid_seen", seen, 1);
    araddr = 12'h014; arvalid = 1; hb = 0; ha = 0;
    repeat (10) begin
      @(posedge aclk); #1;
      hb += int'(bvalid); ha += int'(arready);
    end
    check("hold_bvalid_cycles", hb, 10);
    check("hold_arready_blocked", ha, 0);
    bready = 1; @(posedge aclk); #1; bready = 0;
    check("hold_bvalid_released", bvalid, 0);
    @(posedge aclk); #1;
    check("hold_arready_after", arready, 1);
    arvalid = 0; rready = 0;
    @(posedge aclk); #1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (rvalid !== 1'b1 || rdata !== 32'hCAFEF00D || rresp !== 2'b00) bad++;
      @(posedge aclk); #1;
    end
    check("hold_rdata_stable_bad_cycles", bad, 0);
    rready = 1; @(posedge aclk); #1; rready = 0;
    check("hold_rvalid_released", rvalid, 0);
    $display("txn hold sequence done");

    // Fabric read during the AXI write cycle of the same word sees the old value.
    fab_en = 1; fab_addr = 9'd3; @(posedge aclk); #1; fab_en = 0;
    check("fab_plain", fab_data, 32'h4);
    awaddr = 12'h00C; wdata = 32'h33333333; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(posedge aclk); #1;
    check("fab_wr_acc", awready, 1);
    awvalid = 0; wvalid = 0; fab_en = 1; fab_addr = 9'd3;
    @(posedge aclk); #1;
    check("fab_read_first", fab_data, 32'h4);
    @(posedge aclk); #1;
    fab_en = 0; fab_addr = 9'd0; bready = 0;
    check("fab_new_value", fab_data, 32'h33333333);
    @(posedge aclk); #1;
    check("fab_hold", fab_data, 32'h33333333);
    $display("txn fabric read-first sequence done");

    // Reset while in WR_RESP: response dropped at once, RAM keeps the write.
    awaddr = 12'h018; wdata = 32'h600D600D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge aclk); #1;
      if (awready) begin awvalid = 0; wvalid = 0; end
      if (bvalid) seen = 1;
    end
    awvalid = 0; wvalid = 0;
    check("rst_bvalid_before", seen, 1);
    areset = 1; #1;
    check("rst_bvalid_dropped", bvalid, 0);
    check("rst_fab_cleared", fab_data, 32'h0);
    @(negedge aclk) areset = 0;
    @(posedge aclk); #1;
    axi_read(12'h018, d, resp, lat);
    $display("txn read after reset addr=0x018 rdata=0x%08h rresp=%b", d, resp);
    check("rst_ram_retained", d, 32'h600D600D);
    check("rst_ram_rresp", resp, 2'b00);

    // Arbitration: round-robin instance.
    do_reset();
    sel = 0;
    contend(12'h100, 12'h000, f1, s1);
    contend(12'h104, 12'h004, f2, s2);
    $display("txn rr contention order %0d,%0d then %0d,%0d", f1, s1, f2, s2);
    check("rr_first_grant", f1, 1);
    check("rr_second_grant", s1, 2);
    check("rr_round2_first", f2, 2);
    // Arbitration: write-priority instance.
    do_reset();
    sel = 1;
    contend(12'h100, 12'h000, f1, s1);
    contend(12'h104, 12'h004, f2, s2);
    $display("txn fw contention order %0d,%0d then %0d,%0d", f1, s1, f2, s2);
    check("fw_first_grant", f1, 1);
    check("fw_round2_first", f2, 1);
    sel = 0;
    do_reset();

    // Randomized traffic against the word-array model.
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      model_wr(i, d, 4'hF, eresp);
      axi_write(12'(i*4), d, 4'hF, resp, lat);
      check("prefill_bresp", resp, eresp);
    end
    for (int n = 0; n < 150; n++) begin
      int r, idx;
      logic [AW-1:0] a;
      logic [3:0] s;
      r = $urandom_range(0, 9);
      idx = ($urandom_range(0, 7) == 0) ? $urandom_range(512, 1023) : $urandom_range(0, 31);
      a = 12'(idx*4 + $urandom_range(0, 3));
      if (r < 4) begin
        d = $urandom; s = 4'($urandom_range(0, 15));
        model_wr(idx, d, s, eresp);
        axi_write(a, d, s, resp, lat);
        $display("txn %0d write addr=0x%03h data=0x%08h strb=%h bresp=%b", n, a, d, s, resp);
        check("rand_bresp", resp, eresp);
        check("rand_blat", lat, 2);
      end else if (r < 8) begin
        ed = model_rd(idx);
        eresp = (idx >= DEPTH) ? 2'b10 : 2'b00;
        axi_read(a, d, resp, lat);
        $display("txn %0d read  addr=0x%03h rdata=0x%08h rresp=%b", n, a, d, resp);
        check("rand_rdata", d, ed);
        check("rand_rresp", resp, eresp);
        check("rand_rlat", lat, 2);
      end else begin
        idx = $urandom_range(0, 31);
        fab_en = 1; fab_addr = 9'(idx);
        @(posedge aclk); #1;
        fab_en = 0;
        $display("txn %0d fabric idx=%0d data=0x%08h", n, idx, fab_data);
        check("rand_fab", fab_data, model_rd(idx));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
